// File: rtl/zicsr_access_ctrl_pkg.sv
// Shared types and constants for the Zicsr access controller: operation and
// FSM encodings, the per-CSR descriptor, architectural addresses and the
// read-modify helper.
`ifndef XLEN
`define XLEN 32
`endif

package ZICSRType;

  localparam int XLEN    = `XLEN;
  localparam int NUM_CSR = 4;

  // Storage slot order inside the controller.
  localparam int IDX_USTATUS = 0;
  localparam int IDX_MSTATUS = 1;
  localparam int IDX_MTVEC   = 2;
  localparam int IDX_MHARTID = 3;

  // Architectural CSR addresses used as descriptor Names.
  localparam logic [11:0] USTATUS_NAME = 12'h000;
  localparam logic [11:0] MSTATUS_NAME = 12'h300;
  localparam logic [11:0] MTVEC_NAME   = 12'h305;
  localparam logic [11:0] MHARTID_NAME = 12'hF14;

  localparam logic [XLEN-1:0] MSTATUS_DEFAULT = XLEN'(32'h0000_1880);
  localparam logic [XLEN-1:0] MTVEC_DEFAULT   = XLEN'(32'h8000_0000);

  typedef enum logic [1:0] {
    RW = 2'b01,
    RS = 2'b10,
    RC = 2'b11
  } csrOp;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } csr_state_e;

  typedef struct packed {
    logic [11:0]     Name;
    logic [XLEN-1:0] DefaultValue;
    logic            WriteEn;
    logic            ReadEn;
    logic            InternalWriteEn;
    logic [XLEN-1:0] InternalWriteData;
  } csrCtrl;

  // Value a CSR instruction would leave in the register given the captured
  // old value. An unknown opcode leaves the old value untouched.
  function automatic logic [XLEN-1:0] csr_modify(input csrOp op,
                                                  input logic [XLEN-1:0] old_val,
                                                  input logic [XLEN-1:0] wdata);
    logic [XLEN-1:0] res;
    res = old_val;
    case (op)
      RW:      res = wdata;
      RS:      res = old_val | wdata;
      RC:      res = old_val & ~wdata;
      default: res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/zicsr_access_ctrl_lookup.sv
// Combinational CSR address decoder: matches the latched address against the
// descriptor Names and returns hit, one-hot slot, permissions and value.
module zicsr_csr_lookup
  import ZICSRType::*;
(
  input  logic [11:0]        addr_i,
  input  logic [11:0]        name_i     [NUM_CSR],
  input  logic [NUM_CSR-1:0] read_en_i,
  input  logic [NUM_CSR-1:0] write_en_i,
  input  logic [XLEN-1:0]    value_i    [NUM_CSR],
  output logic               hit_o,
  output logic [NUM_CSR-1:0] onehot_o,
  output logic               read_en_o,
  output logic               write_en_o,
  output logic [XLEN-1:0]    value_o
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CSR; gi++) begin : g_match
      assign onehot_o[gi] = (addr_i == name_i[gi]);
    end
  endgenerate

  assign hit_o      = |onehot_o;
  assign read_en_o  = |(onehot_o & read_en_i);
  assign write_en_o = |(onehot_o & write_en_i);

  // One-hot OR mux of the selected register value (zero on a miss).
  always_comb begin
    value_o = '0;
    for (int i = 0; i < NUM_CSR; i++) begin
      if (onehot_o[i]) value_o = value_o | value_i[i];
    end
  end

endmodule

// File: rtl/zicsr_access_ctrl.sv
// Zicsr access controller: holds ustatus/mstatus/mtvec/mhartid, serialises
// CSRRW/CSRRS/CSRRC through IDLE->READ->WRITE->RESP and lets per-cycle
// internal writes override software commits to the same CSR.
module zicsr_access_ctrl
  import ZICSRType::*;
(
  input  logic            clk,
  input  logic            reset,
  input  csrCtrl          ustatus_ctrl,
  input  csrCtrl          mstatus_ctrl,
  input  csrCtrl          mtvec_ctrl,
  input  csrCtrl          mhartid_ctrl,
  input  logic            ReqValid,
  output logic            ReqReady,
  input  csrOp            ReqOp,
  input  logic [11:0]     ReqAddr,
  input  logic [XLEN-1:0] ReqWData,
  input  logic            Flush,
  output logic            RspValid,
  input  logic            RspReady,
  output logic [XLEN-1:0] RspRData,
  output logic            RspIllegal,
  output logic            RspDropped,
  output logic [XLEN-1:0] ustatus_q,
  output logic [XLEN-1:0] mstatus_q,
  output logic [XLEN-1:0] mtvec_q,
  output logic [XLEN-1:0] mhartid_q
);

  csrCtrl             ctrl_a   [NUM_CSR];
  logic [11:0]        name_a   [NUM_CSR];
  logic [NUM_CSR-1:0] re_vec;
  logic [NUM_CSR-1:0] we_vec;
  logic [NUM_CSR-1:0] iwe_vec;

  logic [XLEN-1:0]    csr_q    [NUM_CSR];
  logic [XLEN-1:0]    csr_d    [NUM_CSR];

  csr_state_e         state_q, state_d;
  csrOp               op_q;
  logic [11:0]        addr_q;
  logic [XLEN-1:0]    wdata_q;
  logic [XLEN-1:0]    old_q;
  logic               illegal_q;
  logic               intent_q;
  logic               dropped_q;
  logic [NUM_CSR-1:0] target_q;
  logic [XLEN-1:0]    rsp_rdata_q;
  logic               rsp_illegal_q;
  logic               rsp_dropped_q;

  logic               lk_hit;
  logic [NUM_CSR-1:0] lk_onehot;
  logic               lk_read_en;
  logic               lk_write_en;
  logic [XLEN-1:0]    lk_value;

  logic               intent_now;
  logic               dropped_now;
  logic               commit;
  logic [XLEN-1:0]    new_val;

  assign ctrl_a[IDX_USTATUS] = ustatus_ctrl;
  assign ctrl_a[IDX_MSTATUS] = mstatus_ctrl;
  assign ctrl_a[IDX_MTVEC]   = mtvec_ctrl;
  assign ctrl_a[IDX_MHARTID] = mhartid_ctrl;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CSR; gi++) begin : g_desc
      assign name_a[gi]  = ctrl_a[gi].Name;
      assign re_vec[gi]  = ctrl_a[gi].ReadEn;
      assign we_vec[gi]  = ctrl_a[gi].WriteEn;
      assign iwe_vec[gi] = ctrl_a[gi].InternalWriteEn;
    end
  endgenerate

  zicsr_csr_lookup u_lookup (
    .addr_i     (addr_q),
    .name_i     (name_a),
    .read_en_i  (re_vec),
    .write_en_i (we_vec),
    .value_i    (csr_q),
    .hit_o      (lk_hit),
    .onehot_o   (lk_onehot),
    .read_en_o  (lk_read_en),
    .write_en_o (lk_write_en),
    .value_o    (lk_value)
  );

  // A zero mask on RS/RC is a pure read; RW always writes.
  assign intent_now  = (op_q == RW) || (wdata_q != '0);
  // An internal write to the target in either READ or WRITE loses the software write.
  assign dropped_now = dropped_q | (|(target_q & iwe_vec));
  assign new_val     = csr_modify(op_q, old_q, wdata_q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake/commit decode.
  always_comb begin
    state_d  = state_q;
    ReqReady = 1'b0;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) state_d = READ;
      end
      READ: begin
        state_d = Flush ? IDLE : WRITE;
      end
      WRITE: begin
        commit  = intent_q & ~illegal_q & ~dropped_now;
        state_d = RESP;
      end
      RESP: begin
        if (RspReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latches, READ-stage capture and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q          <= RW;
      addr_q        <= '0;
      wdata_q       <= '0;
      old_q         <= '0;
      illegal_q     <= 1'b0;
      intent_q      <= 1'b0;
      dropped_q     <= 1'b0;
      target_q      <= '0;
      rsp_rdata_q   <= '0;
      rsp_illegal_q <= 1'b0;
      rsp_dropped_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ReqValid) begin
            op_q    <= ReqOp;
            addr_q  <= ReqAddr;
            wdata_q <= ReqWData;
          end
        end
        READ: begin
          old_q     <= lk_read_en ? lk_value : '0;
          illegal_q <= ~lk_hit | (intent_now & ~lk_write_en);
          intent_q  <= intent_now;
          target_q  <= lk_onehot;
          dropped_q <= |(lk_onehot & iwe_vec);
        end
        WRITE: begin
          rsp_rdata_q   <= illegal_q ? '0 : old_q;
          rsp_illegal_q <= illegal_q;
          rsp_dropped_q <= dropped_now;
        end
        default: ;
      endcase
    end
  end

  // Per-CSR storage: reset to descriptor default, internal write beats software commit.
  generate
    for (gi = 0; gi < NUM_CSR; gi++) begin : g_csr
      assign csr_d[gi] = ctrl_a[gi].InternalWriteEn       ? ctrl_a[gi].InternalWriteData :
                         (commit && target_q[gi])         ? new_val :
                                                            csr_q[gi];
      always_ff @(posedge clk) begin
        if (reset) csr_q[gi] <= ctrl_a[gi].DefaultValue;
        else       csr_q[gi] <= csr_d[gi];
      end
    end
  endgenerate

  assign RspValid   = (state_q == RESP);
  assign RspRData   = rsp_rdata_q;
  assign RspIllegal = rsp_illegal_q;
  assign RspDropped = rsp_dropped_q;

  assign ustatus_q  = csr_q[IDX_USTATUS];
  assign mstatus_q  = csr_q[IDX_MSTATUS];
  assign mtvec_q    = csr_q[IDX_MTVEC];
  assign mhartid_q  = csr_q[IDX_MHARTID];

endmodule

// File: tb/tb_zicsr_access_ctrl.sv
// Directed bench for zicsr_access_ctrl: each request is driven on the falling
// edge, responses and registers are sampled on the falling edge.
module tb_zicsr_access_ctrl;
  import ZICSRType::*;

  logic        clk = 1'b0;
  logic        reset;
  csrCtrl      ctrl [NUM_CSR];
  logic        ReqValid;
  logic        ReqReady;
  csrOp        ReqOp;
  logic [11:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        Flush;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] RspRData;
  logic        RspIllegal;
  logic        RspDropped;
  logic [31:0] ustatus_q, mstatus_q, mtvec_q, mhartid_q;

  int          n_checks = 0;
  int          n_errors = 0;

  logic [31:0] r_rdata;
  logic        r_illegal, r_dropped, r_got;
  int          r_lat;
  logic [31:0] snap_q [NUM_CSR];

  always #5 clk = ~clk;

  zicsr_access_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .ustatus_ctrl (ctrl[0]),
    .mstatus_ctrl (ctrl[1]),
    .mtvec_ctrl   (ctrl[2]),
    .mhartid_ctrl (ctrl[3]),
    .ReqValid     (ReqValid),
    .ReqReady     (ReqReady),
    .ReqOp        (ReqOp),
    .ReqAddr      (ReqAddr),
    .ReqWData     (ReqWData),
    .Flush        (Flush),
    .RspValid     (RspValid),
    .RspReady     (RspReady),
    .RspRData     (RspRData),
    .RspIllegal   (RspIllegal),
    .RspDropped   (RspDropped),
    .ustatus_q    (ustatus_q),
    .mstatus_q    (mstatus_q),
    .mtvec_q      (mtvec_q),
    .mhartid_q    (mhartid_q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_hooks();
    for (int k = 0; k < NUM_CSR; k++) ctrl[k].InternalWriteEn = 1'b0;
    Flush = 1'b0;
    reset = 1'b0;
  endtask

  // Issue one request. iw_at/flush_at/rst_at name the cycle after the
  // handshake (1 = READ, 2 = WRITE) in which that event is applied; 0 = never.
  // hold = number of cycles RspReady is kept low once the response appears.
  task automatic do_req(input string tag, input csrOp op, input logic [11:0] addr,
                        input logic [31:0] wdata, input int iw_idx, input logic [31:0] iw_data,
                        input int iw_at, input int flush_at, input int rst_at,
                        input int hold, input logic [31:0] exp_rdata);
    @(negedge clk);
    check({tag, ".ready"}, {31'd0, ReqReady}, 32'd1);
    ReqValid = 1'b1;
    ReqOp    = op;
    ReqAddr  = addr;
    ReqWData = wdata;
    RspReady = (hold == 0);
    @(posedge clk);
    #1 ReqValid = 1'b0;
    r_got = 1'b0; r_lat = 0; r_rdata = '0; r_illegal = 1'b0; r_dropped = 1'b0;
    for (int c = 1; c <= 8 && !r_got; c++) begin
      @(negedge clk);
      clear_hooks();
      if (RspValid) begin
        r_got = 1'b1; r_lat = c;
        r_rdata = RspRData; r_illegal = RspIllegal; r_dropped = RspDropped;
        snap_q[0] = ustatus_q; snap_q[1] = mstatus_q; snap_q[2] = mtvec_q; snap_q[3] = mhartid_q;
      end else begin
        if (c == iw_at) begin
          ctrl[iw_idx].InternalWriteEn   = 1'b1;
          ctrl[iw_idx].InternalWriteData = iw_data;
        end
        if (c == flush_at) Flush = 1'b1;
        if (c == rst_at)   reset = 1'b1;
      end
    end
    if (r_got) begin
      for (int h = 1; h <= hold; h++) begin
        @(negedge clk);
        check({tag, ".hold_valid"}, {31'd0, RspValid}, 32'd1);
        check({tag, ".hold_rdata"}, RspRData, exp_rdata);
        check({tag, ".hold_ready"}, {31'd0, ReqReady}, 32'd0);
      end
      RspReady = 1'b1;
      @(posedge clk);
      #1;
    end
    clear_hooks();
    $display("txn %-10s op=%0d addr=%h wdata=%h rsp=%0d lat=%0d rdata=%h ill=%0d drop=%0d",
             tag, op, addr, wdata, r_got, r_lat, r_rdata, r_illegal, r_dropped);
  endtask

  task automatic check_defaults(input string tag);
    check({tag, ".ustatus"}, ustatus_q, 32'h0);
    check({tag, ".mstatus"}, mstatus_q, 32'h0000_1880);
    check({tag, ".mtvec"},   mtvec_q,   32'h8000_0000);
    check({tag, ".mhartid"}, mhartid_q, 32'h0);
    check({tag, ".ready"},   {31'd0, ReqReady}, 32'd1);
    check({tag, ".valid"},   {31'd0, RspValid}, 32'd0);
  endtask

  initial begin
    ctrl[0] = '{Name: 12'h000, DefaultValue: 32'h0,         WriteEn: 1'b1, ReadEn: 1'b1,
                InternalWriteEn: 1'b0, InternalWriteData: 32'h0};
    ctrl[1] = '{Name: 12'h300, DefaultValue: 32'h0000_1880, WriteEn: 1'b1, ReadEn: 1'b1,
                InternalWriteEn: 1'b0, InternalWriteData: 32'h0};
    ctrl[2] = '{Name: 12'h305, DefaultValue: 32'h8000_0000, WriteEn: 1'b1, ReadEn: 1'b0,
                InternalWriteEn: 1'b0, InternalWriteData: 32'h0};
    ctrl[3] = '{Name: 12'hF14, DefaultValue: 32'h0,         WriteEn: 1'b0, ReadEn: 1'b1,
                InternalWriteEn: 1'b0, InternalWriteData: 32'h0};
    reset = 1'b1; ReqValid = 1'b0; ReqOp = RW; ReqAddr = '0; ReqWData = '0;
    Flush = 1'b0; RspReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_defaults("reset");
    check("reset.rdata",   RspRData, 32'h0);
    check("reset.illegal", {31'd0, RspIllegal}, 32'd0);
    check("reset.dropped", {31'd0, RspDropped}, 32'd0);

    // RS mstatus 0x8: old 0x1880, commit visible together with first RspValid
    do_req("rs_mst", RS, 12'h300, 32'h8, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    check("rs_mst.got",   {31'd0, r_got}, 32'd1);
    check("rs_mst.lat",   r_lat, 3);
    check("rs_mst.rdata", r_rdata, 32'h1880);
    check("rs_mst.ill",   {31'd0, r_illegal}, 32'd0);
    check("rs_mst.q_at_rsp", snap_q[1], 32'h1888);

    // RC mstatus 0x80 accepted the cycle after the previous response handshake
    do_req("rc_mst", RC, 12'h300, 32'h80, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    check("rc_mst.rdata", r_rdata, 32'h1888);
    check("rc_mst.q",     mstatus_q, 32'h1808);

    // RW mtvec: not readable, so old value reads as 0
    do_req("rw_mtvec", RW, 12'h305, 32'h100, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    check("rw_mtvec.rdata", r_rdata, 32'h0);
    check("rw_mtvec.ill",   {31'd0, r_illegal}, 32'd0);
    check("rw_mtvec.q",     mtvec_q, 32'h100);

    // RW read-only mhartid: illegal, no commit
    do_req("rw_mhart", RW, 12'hF14, 32'h5, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    check("rw_mhart.ill",   {31'd0, r_illegal}, 32'd1);
    check("rw_mhart.rdata", r_rdata, 32'h0);
    check("rw_mhart.q",     mhartid_q, 32'h0);

    // Internal write while IDLE
    @(negedge clk);
    ctrl[3].InternalWriteEn = 1'b1; ctrl[3].InternalWriteData = 32'h7;
    @(posedge clk);
    #1 ctrl[3].InternalWriteEn = 1'b0;
    @(negedge clk);
    check("iw_idle.q", mhartid_q, 32'h7);

    // RS mhartid with zero mask: legal read of a read-only CSR
    do_req("rs_mhart0", RS, 12'hF14, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    check("rs_mhart0.ill",   {31'd0, r_illegal}, 32'd0);
    check("rs_mhart0.rdata", r_rdata, 32'h7);
    check("rs_mhart0.q",     mhartid_q, 32'h7);

    // Unknown address
    do_req("rw_7c0", RW, 12'h7C0, 32'h1234, 0, 32'h0, 0, 0, 0, 0, 32'h0);
    check("rw_7c0.ill",   {31'd0, r_illegal}, 32'd1);
    check("rw_7c0.rdata", r_rdata, 32'h0);

    // Internal write to target during WRITE: software write dropped
    do_req("drop_wr", RW, 12'h300, 32'hAA, 1, 32'h55, 2, 0, 0, 0, 32'h0);
    check("drop_wr.q",     mstatus_q, 32'h55);
    check("drop_wr.drop",  {31'd0, r_dropped}, 32'd1);
    check("drop_wr.rdata", r_rdata, 32'h1808);

    // Internal write to target during READ: also dropped
    do_req("drop_rd", RW, 12'h000, 32'h3, 0, 32'h9, 1, 0, 0, 0, 32'h0);
    check("drop_rd.q",     ustatus_q, 32'h9);
    check("drop_rd.drop",  {31'd0, r_dropped}, 32'd1);
    check("drop_rd.rdata", r_rdata, 32'h0);

    // Internal write to a different CSR in the commit cycle: both land
    do_req("iw_other", RW, 12'h000, 32'h11, 2, 32'h200, 2, 0, 0, 0, 32'h0);
    check("iw_other.ust",   ustatus_q, 32'h11);
    check("iw_other.mtvec", mtvec_q, 32'h200);
    check("iw_other.drop",  {31'd0, r_dropped}, 32'd0);
    check("iw_other.rdata", r_rdata, 32'h9);

    // Flush in READ: no response, no commit
    do_req("flush_rd", RW, 12'h300, 32'hFF, 0, 32'h0, 0, 1, 0, 0, 32'h0);
    check("flush_rd.got", {31'd0, r_got}, 32'd0);
    check("flush_rd.q",   mstatus_q, 32'h55);

    // Flush in WRITE is ignored
    do_req("flush_wr", RS, 12'h300, 32'h100, 0, 32'h0, 0, 2, 0, 0, 32'h0);
    check("flush_wr.got",   {31'd0, r_got}, 32'd1);
    check("flush_wr.rdata", r_rdata, 32'h55);
    check("flush_wr.q",     mstatus_q, 32'h155);

    // Response back-pressure for 5 cycles
    do_req("hold5", RC, 12'h300, 32'h4, 0, 32'h0, 0, 0, 0, 5, 32'h155);
    check("hold5.rdata", r_rdata, 32'h155);
    check("hold5.q",     mstatus_q, 32'h151);

    // Reset in WRITE (with a concurrent internal write): defaults, no response
    do_req("rst_wr", RW, 12'h305, 32'h300, 1, 32'h77, 2, 0, 2, 0, 32'h0);
    check("rst_wr.got", {31'd0, r_got}, 32'd0);
    check_defaults("rst_wr");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
